// File: rtl/list_fold_pkg.sv
// Shared types for the list_fold consumer: FSM state encoding and fold operation codes.
package list_fold_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        REQ,
        WAIT,
        DONE
    } state_t;

    localparam logic [1:0] OP_SUM = 2'd0;
    localparam logic [1:0] OP_MAX = 2'd1;
    localparam logic [1:0] OP_MIN = 2'd2;

endpackage

// File: rtl/list_fold_alu.sv
// Combinational fold step: the first element loads the accumulator, later ones are summed or compared (signed).
module list_fold_alu
    import list_fold_pkg::*;
#(
    parameter int VAL_W = 8,
    parameter int ACC_W = 16
) (
    input  logic [1:0]       op,
    input  logic             first,
    input  logic [ACC_W-1:0] acc,
    input  logic [VAL_W-1:0] value,
    output logic [ACC_W-1:0] acc_next
);

    logic signed [ACC_W-1:0] value_ext;
    logic signed [ACC_W-1:0] acc_s;

    always_comb begin
        value_ext = ACC_W'($signed(value));
        acc_s     = $signed(acc);
        acc_next  = acc;
        if (first) begin
            acc_next = value_ext;
        end else begin
            case (op)
                OP_MAX:  acc_next = (value_ext > acc_s) ? value_ext : acc_s;
                OP_MIN:  acc_next = (value_ext < acc_s) ? value_ext : acc_s;
                default: acc_next = acc + value_ext;
            endcase
        end
    end

endmodule

// File: rtl/list_fold.sv
// List consumer for the req/ack/eol enumerator protocol; folds a whole list to a sum, max or min.
// Optional element counter output enabled by defining LIST_FOLD_COUNT_EN.
module list_fold
    import list_fold_pkg::*;
#(
    parameter int VAL_W       = 8,
    parameter int ACC_W       = 16,
    parameter int OP          = 0,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [ACC_W-1:0] result,
    output logic             enum_ready,
    output logic             enum_req,
    input  logic             enum_ack,
    input  logic             enum_eol,
    input  logic [VAL_W-1:0] enum_value
`ifdef LIST_FOLD_COUNT_EN
    ,
    output logic [ACC_W-1:0] count
`endif
);

    localparam int TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [1:0] OP_CODE = 2'(OP);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [TMR_W-1:0] timer;
    logic             seen;
`ifdef LIST_FOLD_COUNT_EN
    logic [ACC_W-1:0] cnt;
`endif

    list_fold_alu #(
        .VAL_W (VAL_W),
        .ACC_W (ACC_W)
    ) u_alu (
        .op       (OP_CODE),
        .first    (~seen),
        .acc      (acc),
        .value    (enum_value),
        .acc_next (acc_next)
    );

    // Outputs are registered alongside the state, so each is set on the edge entering its state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            result     <= '0;
            enum_ready <= 1'b0;
            enum_req   <= 1'b0;
            acc        <= '0;
            timer      <= '0;
            seen       <= 1'b0;
`ifdef LIST_FOLD_COUNT_EN
            cnt        <= '0;
            count      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ARM;
                        busy       <= 1'b1;
                        enum_ready <= 1'b1;
                        acc        <= '0;
                        error      <= 1'b0;
                        seen       <= 1'b0;
`ifdef LIST_FOLD_COUNT_EN
                        cnt        <= '0;
`endif
                    end
                end
                ARM: begin
                    state    <= REQ;
                    enum_req <= 1'b1;
                end
                REQ: begin
                    state    <= WAIT;
                    enum_req <= 1'b0;
                    timer    <= '0;
                end
                WAIT: begin
                    if (enum_ack) begin
                        acc  <= acc_next;
                        seen <= 1'b1;
`ifdef LIST_FOLD_COUNT_EN
                        cnt  <= cnt + 1'b1;
`endif
                        if (enum_eol) begin
                            // Last element is folded and published on the same edge.
                            state      <= DONE;
                            enum_ready <= 1'b0;
                            done       <= 1'b1;
                            result     <= acc_next;
`ifdef LIST_FOLD_COUNT_EN
                            count      <= cnt + 1'b1;
`endif
                        end else begin
                            state    <= REQ;
                            enum_req <= 1'b1;
                        end
                    end else if (timer == TMR_LAST) begin
                        state      <= DONE;
                        enum_ready <= 1'b0;
                        done       <= 1'b1;
                        error      <= 1'b1;
                        result     <= acc;
`ifdef LIST_FOLD_COUNT_EN
                        count      <= cnt;
`endif
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    enum_ready <= 1'b0;
                    enum_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_list_fold.sv
// Self-checking bench for list_fold: a bounded enumerator source feeds sum/max/min/8-bit instances.
module tb_list_fold;

    logic clock = 1'b0;
    logic reset_n;
    logic start;
    logic start_to;

    logic        ack, eol;
    logic [7:0]  value;

    logic        busy_sum, done_sum, err_sum, rdy_sum, req_sum;
    logic        busy_max, done_max, err_max, rdy_max, req_max;
    logic        busy_min, done_min, err_min, rdy_min, req_min;
    logic        busy_w8,  done_w8,  err_w8,  rdy_w8,  req_w8;
    logic        busy_to,  done_to,  err_to,  rdy_to,  req_to;
    logic [15:0] res_sum, res_max, res_min, res_to;
    logic [7:0]  res_w8;
`ifdef LIST_FOLD_COUNT_EN
    logic [15:0] cnt_sum, cnt_max, cnt_min, cnt_to;
    logic [7:0]  cnt_w8;
`endif

    int checks = 0;
    int errors = 0;

    int src_min = 0, src_step = 1, src_max = 3;
    int pos;
    logic req_q;

    always #5 clock = ~clock;

    list_fold #(.OP(0)) u_sum (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy_sum), .done(done_sum),
        .error(err_sum), .result(res_sum), .enum_ready(rdy_sum), .enum_req(req_sum),
        .enum_ack(ack), .enum_eol(eol), .enum_value(value)
`ifdef LIST_FOLD_COUNT_EN
        , .count(cnt_sum)
`endif
    );

    list_fold #(.OP(1)) u_max (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy_max), .done(done_max),
        .error(err_max), .result(res_max), .enum_ready(rdy_max), .enum_req(req_max),
        .enum_ack(ack), .enum_eol(eol), .enum_value(value)
`ifdef LIST_FOLD_COUNT_EN
        , .count(cnt_max)
`endif
    );

    list_fold #(.OP(2)) u_min (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy_min), .done(done_min),
        .error(err_min), .result(res_min), .enum_ready(rdy_min), .enum_req(req_min),
        .enum_ack(ack), .enum_eol(eol), .enum_value(value)
`ifdef LIST_FOLD_COUNT_EN
        , .count(cnt_min)
`endif
    );

    list_fold #(.ACC_W(8), .OP(0)) u_w8 (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy_w8), .done(done_w8),
        .error(err_w8), .result(res_w8), .enum_ready(rdy_w8), .enum_req(req_w8),
        .enum_ack(ack), .enum_eol(eol), .enum_value(value)
`ifdef LIST_FOLD_COUNT_EN
        , .count(cnt_w8)
`endif
    );

    list_fold #(.OP(0), .ACK_TIMEOUT(8)) u_to (
        .clock(clock), .reset_n(reset_n), .start(start_to), .busy(busy_to), .done(done_to),
        .error(err_to), .result(res_to), .enum_ready(rdy_to), .enum_req(req_to),
        .enum_ack(1'b0), .enum_eol(1'b0), .enum_value(8'h00)
`ifdef LIST_FOLD_COUNT_EN
        , .count(cnt_to)
`endif
    );

    // Bounded enumerator: position resets while ready is low, answers each req rising edge one cycle later.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pos   <= 0;
            req_q <= 1'b0;
            ack   <= 1'b0;
            eol   <= 1'b0;
            value <= 8'h00;
        end else begin
            req_q <= req_sum;
            ack   <= 1'b0;
            eol   <= 1'b0;
            if (!rdy_sum) begin
                pos <= src_min;
            end else if (req_sum && !req_q) begin
                ack   <= 1'b1;
                value <= pos[7:0];
                eol   <= (pos + src_step > src_max);
                pos   <= pos + src_step;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int mn, input int st, input int mx, output int n,
                                  output longint s, output longint hi, output longint lo);
        int q[$];
        for (int v = mn; v <= mx; v += st) q.push_back(v);
        n  = q.size();
        s  = 0;
        hi = q[0];
        lo = q[0];
        foreach (q[i]) begin
            s += q[i];
            if (q[i] > hi) hi = q[i];
            if (q[i] < lo) lo = q[i];
        end
    endfunction

    task automatic run_fold(input int mn, input int st, input int mx, input bit extra_start,
                            input string tag);
        int n, edges;
        longint s, hi, lo;
        model(mn, st, mx, n, s, hi, lo);
        src_min  = mn;
        src_step = st;
        src_max  = mx;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        edges = 0;
        while (done_sum !== 1'b1 && edges < 400) begin
            @(posedge clock);
            #1;
            edges++;
            start = (extra_start && edges == 3);
        end
        start = 1'b0;
        check({tag, " done"}, 32'(done_sum), 32'(1));
        check({tag, " latency"}, 32'(edges), 32'(2 * n + 1));
        check({tag, " sum"}, 32'(res_sum), 32'(s[15:0]));
        check({tag, " max"}, 32'(res_max), 32'(hi[15:0]));
        check({tag, " min"}, 32'(res_min), 32'(lo[15:0]));
        check({tag, " w8"}, 32'(res_w8), 32'(s[7:0]));
        check({tag, " done_all"}, 32'({done_max, done_min, done_w8}), 32'(3'b111));
        check({tag, " error"}, 32'({err_sum, err_max, err_min, err_w8}), 32'(0));
        check({tag, " ready_at_done"}, 32'(rdy_sum), 32'(0));
`ifdef LIST_FOLD_COUNT_EN
        check({tag, " count"}, 32'(cnt_sum), 32'(n));
        check({tag, " count_w8"}, 32'(cnt_w8), 32'(n & 8'hff));
`endif
        @(posedge clock);
        #1;
        check({tag, " done_pulse"}, 32'(done_sum), 32'(0));
        check({tag, " idle_busy"}, 32'(busy_sum), 32'(0));
        check({tag, " result_held"}, 32'(res_sum), 32'(s[15:0]));
    endtask

    initial begin
        int n_mn, n_st, n_mx, edges;
        reset_n  = 1'b0;
        start    = 1'b0;
        start_to = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst outputs", 32'({busy_sum, done_sum, err_sum, rdy_sum, req_sum}), 32'(0));
        check("rst result", 32'(res_sum), 32'(0));
        check("rst to outputs", 32'({busy_to, done_to, err_to, rdy_to, req_to}), 32'(0));
        @(negedge clock);
        reset_n = 1'b1;

        run_fold(0, 1, 3, 1'b0, "d0_3");
        run_fold(-5, 3, 4, 1'b0, "dneg");
        run_fold(7, 1, 7, 1'b0, "single");
        run_fold(100, 10, 120, 1'b0, "wrap8");

        // Timeout: source never answers.
        @(negedge clock);
        start_to = 1'b1;
        @(posedge clock);
        #1 start_to = 1'b0;
        check("to busy", 32'(busy_to), 32'(1));
        edges = 0;
        while (done_to !== 1'b1 && edges < 200) begin
            @(posedge clock);
            #1;
            edges++;
        end
        check("to done", 32'(done_to), 32'(1));
        check("to error", 32'(err_to), 32'(1));
        check("to result", 32'(res_to), 32'(0));
`ifdef LIST_FOLD_COUNT_EN
        check("to count", 32'(cnt_to), 32'(0));
`endif
        @(posedge clock);
        #1;
        check("to ready_after", 32'({rdy_to, busy_to, req_to}), 32'(0));
        check("to error_held", 32'(err_to), 32'(1));

        // Reset during WAIT abandons the fold.
        src_min  = 0;
        src_step = 1;
        src_max  = 3;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("rst mid outputs", 32'({busy_sum, done_sum, err_sum, rdy_sum, req_sum}), 32'(0));
        check("rst mid result", 32'(res_sum), 32'(0));
        check("rst mid to error", 32'(err_to), 32'(0));
        repeat (3) begin
            @(posedge clock);
            #1;
            check("rst no done", 32'(done_sum), 32'(0));
        end
        @(negedge clock);
        reset_n = 1'b1;
        run_fold(0, 1, 3, 1'b1, "after_rst");

        for (int i = 0; i < 8; i++) begin
            n_mn = int'($urandom_range(120)) - 60;
            n_st = int'($urandom_range(15, 1));
            n_mx = n_mn + int'($urandom_range(60));
            run_fold(n_mn, n_st, n_mx, 1'(i % 2), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
